// File: rtl/alu_seq_if.sv
// Signal bundle between a command source, the alu_seq sequencer and the ALU it drives.
// The slave view is the sequencer; the master view is the command source plus ALU.
interface alu_seq_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) ();
  logic              Req_Valid_i;
  logic              Req_Ready_o;
  logic [1:0]        Req_Opc_i;
  logic [DATA_W-1:0] Req_DinA_i;
  logic [DATA_W-1:0] Req_DinB_i;

  logic [1:0]        Alu_Opc_o;
  logic [DATA_W-1:0] Alu_DinA_o;
  logic [DATA_W-1:0] Alu_DinB_o;
  logic [DATA_W-1:0] Alu_Dout_i;
  logic              Alu_OverFlow_i;

  logic              Rsp_Valid_o;
  logic              Rsp_Ready_i;
  logic [DATA_W-1:0] Rsp_Dout_o;
  logic              Rsp_OverFlow_o;

  logic              Busy_o;
  logic              Err_o;
  logic [CNT_W-1:0]  OpCount_o;

  modport slave (
    input  Req_Valid_i, Req_Opc_i, Req_DinA_i, Req_DinB_i,
    input  Alu_Dout_i, Alu_OverFlow_i, Rsp_Ready_i,
    output Req_Ready_o, Alu_Opc_o, Alu_DinA_o, Alu_DinB_o,
    output Rsp_Valid_o, Rsp_Dout_o, Rsp_OverFlow_o,
    output Busy_o, Err_o, OpCount_o
  );

  modport master (
    output Req_Valid_i, Req_Opc_i, Req_DinA_i, Req_DinB_i,
    output Alu_Dout_i, Alu_OverFlow_i, Rsp_Ready_i,
    input  Req_Ready_o, Alu_Opc_o, Alu_DinA_o, Alu_DinB_o,
    input  Rsp_Valid_o, Rsp_Dout_o, Rsp_OverFlow_o,
    input  Busy_o, Err_o, OpCount_o
  );
endinterface

// File: rtl/alu_seq.sv
// Request-side sequencer for a 1-cycle-latency ADD/SUB/AND/OR ALU, with a
// built-in result checker that raises a sticky error on any wrong ALU answer.
module alu_seq #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic     Clk_i,
  input  logic     Reset_n_i,
  alu_seq_if.slave bus
);
  localparam logic [1:0] OPC_ADD = 2'd0;
  localparam logic [1:0] OPC_SUB = 2'd1;
  localparam logic [1:0] OPC_AND = 2'd2;
  localparam logic [1:0] OPC_OR  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              w_accept;
  logic              w_capture;
  logic              w_rsp_hs;

  logic [1:0]        r_alu_opc;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;

  logic [1:0]        r_exp_opc;
  logic [DATA_W-1:0] r_exp_a;
  logic [DATA_W-1:0] r_exp_b;

  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_dout;
  logic              r_rsp_ovf;
  logic              r_err;
  logic [CNT_W-1:0]  r_op_cnt;

  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_diff;
  logic [DATA_W-1:0] w_exp_dout;
  logic              w_exp_ovf;
  logic              w_ovf_checked;
  logic              w_mismatch;

  always_ff @(posedge Clk_i) begin
    if (!Reset_n_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_rsp_hs     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.Req_Valid_i) begin
          w_accept     = 1'b1;
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: w_state_next = S_WAIT;
      S_WAIT: begin
        w_capture    = 1'b1;
        w_state_next = S_RESP;
      end
      S_RESP: begin
        if (bus.Rsp_Ready_i) begin
          w_rsp_hs     = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Widened by one bit so the top bit is the carry (ADD) or borrow (SUB).
  assign w_sum  = {1'b0, r_exp_a} + {1'b0, r_exp_b};
  assign w_diff = {1'b0, r_exp_a} - {1'b0, r_exp_b};

  always_comb begin
    w_exp_dout    = '0;
    w_exp_ovf     = 1'b0;
    w_ovf_checked = 1'b0;
    case (r_exp_opc)
      OPC_ADD: begin
        w_exp_dout    = w_sum[DATA_W-1:0];
        w_exp_ovf     = w_sum[DATA_W];
        w_ovf_checked = 1'b1;
      end
      OPC_SUB: begin
        w_exp_dout    = w_diff[DATA_W-1:0];
        w_exp_ovf     = w_diff[DATA_W];
        w_ovf_checked = 1'b1;
      end
      OPC_AND: w_exp_dout = r_exp_a & r_exp_b;
      OPC_OR:  w_exp_dout = r_exp_a | r_exp_b;
      default: w_exp_dout = '0;
    endcase
  end

  // A spurious overflow from the ALU is tolerated; only a missing one is flagged.
  assign w_mismatch = (bus.Alu_Dout_i != w_exp_dout) ||
                      (w_ovf_checked && w_exp_ovf && !bus.Alu_OverFlow_i);

  always_ff @(posedge Clk_i) begin
    if (!Reset_n_i) begin
      r_alu_opc   <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_exp_opc   <= '0;
      r_exp_a     <= '0;
      r_exp_b     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_dout  <= '0;
      r_rsp_ovf   <= 1'b0;
      r_err       <= 1'b0;
      r_op_cnt    <= '0;
    end else begin
      if (w_accept) begin
        r_alu_opc <= bus.Req_Opc_i;
        r_alu_a   <= bus.Req_DinA_i;
        r_alu_b   <= bus.Req_DinB_i;
        r_exp_opc <= bus.Req_Opc_i;
        r_exp_a   <= bus.Req_DinA_i;
        r_exp_b   <= bus.Req_DinB_i;
      end
      if (w_capture) begin
        r_rsp_valid <= 1'b1;
        r_rsp_dout  <= bus.Alu_Dout_i;
        r_rsp_ovf   <= bus.Alu_OverFlow_i;
        r_err       <= r_err | w_mismatch;
      end
      if (w_rsp_hs) begin
        r_rsp_valid <= 1'b0;
        r_op_cnt    <= r_op_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.Req_Ready_o    = (r_state == S_IDLE);
  assign bus.Busy_o         = (r_state != S_IDLE);
  assign bus.Alu_Opc_o      = r_alu_opc;
  assign bus.Alu_DinA_o     = r_alu_a;
  assign bus.Alu_DinB_o     = r_alu_b;
  assign bus.Rsp_Valid_o    = r_rsp_valid;
  assign bus.Rsp_Dout_o     = r_rsp_dout;
  assign bus.Rsp_OverFlow_o = r_rsp_ovf;
  assign bus.Err_o          = r_err;
  assign bus.OpCount_o      = r_op_cnt;
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Request-side sequencer that drives the 2-operand ALU (opcodes ADD/SUB/AND/OR, registered output, 1-cycle latency). It accepts operations on a valid/ready request channel, presents them to the ALU, captures the result and returns it on a valid/ready response channel. An embedded result checker recomputes each expected result and raises a sticky error on any mismatch. It sits between a command source (CPU/bench) and the ALU instance.

Parameters:
DATA_W, 32, operand/result width (ALU width).
CNT_W, 16, width of completed-operation counter.

Ports:
Clk_i  in  1  clock, all logic on rising edge
Reset_n_i  in  1  reset, synchronous, active-low
Req_Valid_i  in  1  request valid
Req_Ready_o  out  1  request ready
Req_Opc_i  in  2  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR
Req_DinA_i  in  DATA_W  operand A
Req_DinB_i  in  DATA_W  operand B
Alu_Opc_o  out  2  opcode to ALU
Alu_DinA_o  out  DATA_W  operand A to ALU
Alu_DinB_o  out  DATA_W  operand B to ALU
Alu_Dout_i  in  DATA_W  ALU result (valid 1 cycle after inputs sampled)
Alu_OverFlow_i  in  1  ALU overflow/borrow flag
Rsp_Valid_o  out  1  response valid
Rsp_Ready_i  in  1  response ready
Rsp_Dout_o  out  DATA_W  captured result
Rsp_OverFlow_o  out  1  captured overflow flag
Busy_o  out  1  high in any state other than IDLE
Err_o  out  1  sticky checker error
OpCount_o  out  CNT_W  completed responses, wraps

Behaviour:
- Reset (Reset_n_i=0 at a rising edge): state IDLE; Req_Ready_o=1 after reset; Rsp_Valid_o=0, Rsp_Dout_o=0, Rsp_OverFlow_o=0; Alu_Opc_o=0, Alu_DinA_o=0, Alu_DinB_o=0; Busy_o=0; Err_o=0; OpCount_o=0. Reset mid-operation abandons the operation; no response is produced.
- FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE: Req_Ready_o=1. On Req_Valid_i=1 at edge k: register Req_Opc_i/DinA/DinB into Alu_*_o and into an expected-value shadow; go to ISSUE.
- ISSUE: ALU inputs stable; the ALU samples them at edge k+1; go to WAIT.
- WAIT: Alu_Dout_i/Alu_OverFlow_i are valid. At edge k+2, capture them into Rsp_Dout_o/Rsp_OverFlow_o, set Rsp_Valid_o=1, run checker, go to RESP.
- RESP: Rsp_Valid_o and Rsp_* held stable until Rsp_Ready_i=1. On handshake edge: Rsp_Valid_o=0, OpCount_o+1 (mod 2^CNT_W), go to IDLE.
- Req_Ready_o=0 in ISSUE/WAIT/RESP. A request is never accepted in the same cycle as a response handshake. Minimum 4 cycles per operation with Rsp_Ready_i tied high.
- Alu_*_o hold last issued values until the next accept.
- Req_Valid_i with Req_Ready_o=0 is ignored; the source must hold it.
- Checker, evaluated at the WAIT->RESP edge on (DATA_W+1)-bit zero-extended operands:
  - ADD: expected Dout = (A+B) mod 2^DATA_W; expected overflow = carry out.
  - SUB: expected Dout = (A-B) mod 2^DATA_W; expected overflow = borrow (A<B).
  - AND/OR: bitwise; overflow not checked.
  - Err_o is set if Alu_Dout_i differs from expected, or if expected overflow=1 and Alu_OverFlow_i=0 (ADD/SUB only).
  - Err_o stays set until reset. The response is still delivered unchanged.

Test Plan:
- ADD A=0xFFFF_FFFF B=0x0000_0001, Rsp_Ready_i=1 -> Rsp_Valid_o high 2 cycles after accept; Rsp_Dout_o=0, Rsp_OverFlow_o=1, Err_o=0, OpCount_o=1.
- SUB A=3 B=5 -> Rsp_Dout_o=0xFFFF_FFFE, Rsp_OverFlow_o=1. AND 0xF0F0_F0F0 & 0x0FF0_0FF0 -> 0x00F0_00F0. OR same operands -> 0xFFF0_FFF0. OpCount_o=3 after all three.
- Backpressure: Rsp_Ready_i=0 for 5 cycles in RESP -> Rsp_* stable, Req_Ready_o=0, new Req_Valid_i not accepted; on Rsp_Ready_i=1 -> IDLE, next request accepted on the following edge.
- Faulty ALU model (returns Dout+1 on ADD 2+2) -> Rsp_Dout_o=5, Err_o=1; Err_o stays 1 through later correct ops until reset.
- Reset asserted in WAIT -> next cycle all outputs at reset values, no Rsp_Valid_o, OpCount_o=0. Then ADD 1+1 -> Rsp_Dout_o=2.
- Counter wrap with CNT_W=2: 5 back-to-back ops -> OpCount_o sequence 1,2,3,0,1.
